psone_frame_rx: RTL and testbench
=================================

Name: psone_frame_rx

Overview:
Byte-stream deframer on the receive side of the PS-one UART byte interface. It consumes the per-byte strobe, data and error flags produced by the UART receiver and parses frames of the form SYNC, LEN, PAYLOAD[LEN], CHK. It publishes a validated payload to the gamepad logic with a one-cycle valid pulse, or a one-cycle error pulse with an error code. It sits between the UART receiver and the gamepad report/command logic.

Parameters:
SYNC_BYTE, 8'h5A, start-of-frame marker.
MAX_LEN, 8, maximum payload length in bytes, range 1..15.
TIMEOUT, 18'd156250, inter-byte timeout in iCLK cycles: 3 byte times at 9600 baud on a 50 MHz clock.

Ports:
iCLK  in  1  master clock.
iRESET  in  1  synchronous, active-low reset.
iREC_END  in  1  one-cycle strobe; iRX_BYTE holds a new received byte.
iRX_BYTE  in  8  received byte; sampled only when iREC_END=1.
iREC_ER  in  1  one-cycle UART framing-error strobe.
oFRAME_VALID  out  1  one-cycle pulse; frame accepted and oLEN/oPAYLOAD updated.
oLEN  out  4  payload length of the last accepted frame.
oPAYLOAD  out  8*MAX_LEN  payload of the last accepted frame; byte k at [8k+7:8k]; unused bytes are 0.
oFRAME_ER  out  1  one-cycle pulse; frame aborted.
oER_CODE  out  3  reason for the last abort: 0 none, 1 line error, 2 bad length, 3 checksum, 4 timeout. Holds until the next abort or reset.
oBUSY  out  1  high when the state is not IDLE.
oDROP_CNT  out  8  saturating count (max 255) of bytes discarded while in IDLE.

Behaviour:
- Reset (iRESET=0, sampled on posedge iCLK):
  - State returns to IDLE.
  - All outputs go to 0; the shadow buffer, checksum accumulator and timeout counter clear.
  - Reset has priority over every other event, including mid-frame. A partial frame is dropped with no oFRAME_ER pulse.
- FSM states: IDLE, GET_LEN, GET_DATA, GET_CHK, DONE, ERR.
- IDLE:
  - iREC_END with byte == SYNC_BYTE -> GET_LEN; clear accumulator and byte index.
  - iREC_END with any other byte -> stay in IDLE; oDROP_CNT += 1, saturating at 255.
  - iREC_ER is ignored in IDLE.
- GET_LEN, on iREC_END:
  - LEN==0 or LEN>MAX_LEN -> ERR, code 2.
  - Otherwise store LEN, set acc=LEN, go to GET_DATA.
- GET_DATA, on iREC_END:
  - Write the byte to shadow[index]; acc ^= byte; index += 1.
  - When index reaches LEN -> GET_CHK.
- GET_CHK, on iREC_END:
  - byte == acc -> DONE.
  - Otherwise -> ERR, code 3.
- DONE (one cycle):
  - Copy shadow[0..LEN-1] to oPAYLOAD, zero the bytes at index LEN and above, set oLEN=LEN.
  - Assert oFRAME_VALID for that cycle, then go to IDLE.
  - Latency: oFRAME_VALID is high exactly 1 cycle after the iREC_END of the CHK byte.
- ERR (one cycle):
  - Assert oFRAME_ER, latch oER_CODE, go to IDLE.
  - oLEN and oPAYLOAD are left unchanged. Only a successful frame updates them.
- Line error: iREC_ER in GET_LEN, GET_DATA or GET_CHK -> ERR, code 1.
  - If iREC_ER and iREC_END are both high in the same cycle, iREC_ER wins and the byte is dropped.
- Timeout:
  - The counter runs only in GET_LEN, GET_DATA and GET_CHK, and resets to 0 on every iREC_END.
  - When it reaches TIMEOUT-1 with no byte arriving -> ERR, code 4.
  - If the timeout and iREC_END coincide, the byte is taken and the counter clears.
- Bytes arriving during DONE or ERR are treated as IDLE input; a SYNC byte in that cycle starts a new frame.
- A SYNC_BYTE value inside LEN, DATA or CHK positions is ordinary data; there is no resync mid-frame.
- Checksum: 8-bit XOR of LEN and all payload bytes.

Test Plan:
- Good frame: bytes 5A,02,11,22,31 spaced 100 cycles -> oFRAME_VALID 1 cycle after the 5th strobe, oLEN=2, oPAYLOAD[15:0]=16'h2211, upper bytes 0, oFRAME_ER never set.
- Bad checksum: 5A,02,11,22,30 -> oFRAME_ER pulse, oER_CODE=3, oLEN/oPAYLOAD keep the previous frame's values; a following good frame is accepted.
- Bad length: 5A,00 -> ER code 2. Then 5A,09 with MAX_LEN=8 -> ER code 2. Then 5A,08 + 8 bytes + correct CHK -> valid, oLEN=8.
- Noise and drop counter: 300 non-5A bytes in IDLE -> oDROP_CNT=255 (saturated). A SYNC byte of 5A as payload (5A,01,5A,5B) -> valid, payload byte0=5A.
- Timeout: 5A,03,AA then silence -> oFRAME_ER exactly TIMEOUT cycles after the AA strobe, code 4. A byte arriving on the expiry cycle -> no error.
- Line error and reset: iREC_ER mid-DATA -> code 1. iREC_END and iREC_ER together -> code 1. iRESET=0 mid-frame -> all outputs 0, no error pulse, next good frame accepted.

Source files
------------

// File: rtl/psone_frame_rx.sv
// PS-one UART frame deframer: SYNC, LEN, PAYLOAD[LEN], CHK.
// Publishes a validated payload or an abort pulse with a reason code.
module psone_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE = 8'h5A,
    parameter int          MAX_LEN   = 8,
    parameter logic [17:0] TIMEOUT   = 18'd156250
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic                   iREC_END,
    input  logic [7:0]             iRX_BYTE,
    input  logic                   iREC_ER,
    output logic                   oFRAME_VALID,
    output logic [3:0]             oLEN,
    output logic [8*MAX_LEN-1:0]   oPAYLOAD,
    output logic                   oFRAME_ER,
    output logic [2:0]             oER_CODE,
    output logic                   oBUSY,
    output logic [7:0]             oDROP_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_LEN,
        S_GET_DATA,
        S_GET_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_len;
    logic [3:0]             r_idx;
    logic [7:0]             r_acc;
    logic [17:0]            r_tmo;
    logic [8*MAX_LEN-1:0]   r_shadow;
    logic                   r_valid;
    logic                   r_fer;
    logic [2:0]             r_code;
    logic [3:0]             r_olen;
    logic [8*MAX_LEN-1:0]   r_payload;
    logic [7:0]             r_drop;

    logic                   w_in_frame;
    logic                   w_timeout;
    logic                   w_start;
    logic                   w_drop;
    logic                   w_take_data;
    logic [2:0]             w_err_code;

    assign w_in_frame  = (r_state == S_GET_LEN) || (r_state == S_GET_DATA) ||
                         (r_state == S_GET_CHK);
    assign w_timeout   = w_in_frame && !iREC_END && (r_tmo == TIMEOUT - 18'd1);
    assign w_take_data = (r_state == S_GET_DATA) && iREC_END && !iREC_ER;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        w_err_code  = 3'd0;
        unique case (r_state)
            // DONE and ERR last one cycle and accept bytes as if idle
            S_IDLE, S_DONE, S_ERR: begin
                w_state_nxt = S_IDLE;
                if (iREC_END) begin
                    if (iRX_BYTE == SYNC_BYTE) begin
                        w_state_nxt = S_GET_LEN;
                        w_start     = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_GET_LEN: begin
                if (iREC_ER) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 3'd1;
                end else if (iREC_END) begin
                    if (iRX_BYTE == 8'd0 || iRX_BYTE > 8'(MAX_LEN)) begin
                        w_state_nxt = S_ERR;
                        w_err_code  = 3'd2;
                    end else begin
                        w_state_nxt = S_GET_DATA;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 3'd4;
                end
            end
            S_GET_DATA: begin
                if (iREC_ER) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 3'd1;
                end else if (iREC_END) begin
                    if (r_idx + 4'd1 == r_len) w_state_nxt = S_GET_CHK;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 3'd4;
                end
            end
            S_GET_CHK: begin
                if (iREC_ER) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 3'd1;
                end else if (iREC_END) begin
                    if (iRX_BYTE == r_acc) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_code  = 3'd3;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 3'd4;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_state   <= S_IDLE;
            r_len     <= 4'd0;
            r_idx     <= 4'd0;
            r_acc     <= 8'd0;
            r_tmo     <= 18'd0;
            r_shadow  <= '0;
            r_valid   <= 1'b0;
            r_fer     <= 1'b0;
            r_code    <= 3'd0;
            r_olen    <= 4'd0;
            r_payload <= '0;
            r_drop    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == S_DONE);
            r_fer   <= (w_state_nxt == S_ERR);
            if (w_state_nxt == S_ERR) r_code <= w_err_code;
            if (w_in_frame && !iREC_END) r_tmo <= r_tmo + 18'd1;
            else                         r_tmo <= 18'd0;
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            if (w_start) begin
                r_acc <= 8'd0;
                r_idx <= 4'd0;
            end
            if (r_state == S_GET_LEN && w_state_nxt == S_GET_DATA) begin
                r_len <= iRX_BYTE[3:0];
                r_acc <= iRX_BYTE;
            end
            if (w_take_data) begin
                for (int k = 0; k < MAX_LEN; k++)
                    if (4'(k) == r_idx) r_shadow[8*k +: 8] <= iRX_BYTE;
                r_acc <= r_acc ^ iRX_BYTE;
                r_idx <= r_idx + 4'd1;
            end
            // publish on the CHK edge so outputs are visible in DONE
            if (w_state_nxt == S_DONE) begin
                r_olen <= r_len;
                for (int k = 0; k < MAX_LEN; k++)
                    r_payload[8*k +: 8] <= (4'(k) < r_len) ? r_shadow[8*k +: 8] : 8'h00;
            end
        end
    end

    assign oFRAME_VALID = r_valid;
    assign oFRAME_ER    = r_fer;
    assign oER_CODE     = r_code;
    assign oLEN         = r_olen;
    assign oPAYLOAD     = r_payload;
    assign oDROP_CNT    = r_drop;
    assign oBUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_psone_frame_rx.sv
// Scoreboard bench for psone_frame_rx: expected frame/abort events are
// queued as stimulus is driven and compared when the DUT pulses.
module tb_psone_frame_rx;

    localparam int          ML  = 8;
    localparam logic [17:0] TMO = 18'd300;

    logic          clk = 1'b0;
    logic          iRESET;
    logic          iREC_END;
    logic [7:0]    iRX_BYTE;
    logic          iREC_ER;
    logic          oFRAME_VALID;
    logic [3:0]    oLEN;
    logic [8*ML-1:0] oPAYLOAD;
    logic          oFRAME_ER;
    logic [2:0]    oER_CODE;
    logic          oBUSY;
    logic [7:0]    oDROP_CNT;

    typedef struct {
        logic        is_err;
        logic [2:0]  code;
        logic [3:0]  len;
        logic [63:0] payload;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  m_len    = 4'd0;
    logic [63:0] m_pay    = 64'd0;
    int          m_drop   = 0;

    psone_frame_rx #(
        .SYNC_BYTE (8'h5A),
        .MAX_LEN   (ML),
        .TIMEOUT   (TMO)
    ) dut (
        .iCLK         (clk),
        .iRESET       (iRESET),
        .iREC_END     (iREC_END),
        .iRX_BYTE     (iRX_BYTE),
        .iREC_ER      (iREC_ER),
        .oFRAME_VALID (oFRAME_VALID),
        .oLEN         (oLEN),
        .oPAYLOAD     (oPAYLOAD),
        .oFRAME_ER    (oFRAME_ER),
        .oER_CODE     (oER_CODE),
        .oBUSY        (oBUSY),
        .oDROP_CNT    (oDROP_CNT)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (oFRAME_VALID === 1'b1 || oFRAME_ER === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse valid=%0b er=%0b code=%0d required=none",
                         oFRAME_VALID, oFRAME_ER, oER_CODE);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (oFRAME_VALID !== !e.is_err || oFRAME_ER !== e.is_err ||
                    oLEN !== e.len || oPAYLOAD !== e.payload ||
                    (e.is_err && oER_CODE !== e.code)) begin
                    n_fail++;
                    $display("FAIL event got v=%0b e=%0b c=%0d len=%0d pay=%h req v=%0b e=%0b c=%0d len=%0d pay=%h",
                             oFRAME_VALID, oFRAME_ER, oER_CODE, oLEN, oPAYLOAD,
                             !e.is_err, e.is_err, e.code, e.len, e.payload);
                end
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        iREC_END = 1'b1;
        iRX_BYTE = b;
        @(negedge clk);
        iREC_END = 1'b0;
    endtask

    task automatic push_err(input logic [2:0] c);
        exp_t e;
        e.is_err  = 1'b1;
        e.code    = c;
        e.len     = m_len;
        e.payload = m_pay;
        sb.push_back(e);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int len, input logic [119:0] data,
                              input logic [7:0] flip, input int sp);
        exp_t        e;
        logic [7:0]  chk;
        logic [63:0] pay;
        chk = 8'(len);
        pay = '0;
        for (int i = 0; i < len; i++) begin
            chk = chk ^ data[8*i +: 8];
            if (i < 8) pay[8*i +: 8] = data[8*i +: 8];
        end
        chk = chk ^ flip;
        if (flip == 8'd0) begin
            e.is_err  = 1'b0;
            e.code    = 3'd0;
            e.len     = 4'(len);
            e.payload = pay;
            m_len     = 4'(len);
            m_pay     = pay;
        end else begin
            e.is_err  = 1'b1;
            e.code    = 3'd3;
            e.len     = m_len;
            e.payload = m_pay;
        end
        sb.push_back(e);
        send_byte(8'h5A);
        n_checks++;
        if (oBUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_sync got=%0b required=1", oBUSY);
        end
        gap(sp - 1);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            gap(sp - 1);
            send_byte(data[8*i +: 8]);
        end
        gap(sp - 1);
        send_byte(chk);
        n_checks++;
        if ((flip == 8'd0) ? (oFRAME_VALID !== 1'b1) : (oFRAME_ER !== 1'b1)) begin
            n_fail++;
            $display("FAIL frame_latency flip=%h valid=%0b er=%0b required_pulse=1",
                     flip, oFRAME_VALID, oFRAME_ER);
        end
    endtask

    task automatic test_reset;
        iRESET   = 1'b0;
        iREC_END = 1'b0;
        iREC_ER  = 1'b0;
        iRX_BYTE = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({oFRAME_VALID, oFRAME_ER, oBUSY} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b required=000", {oFRAME_VALID, oFRAME_ER, oBUSY});
        end
        n_checks++;
        if ({oLEN, oPAYLOAD, oER_CODE, oDROP_CNT} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs len=%0d pay=%h code=%0d drop=%0d required=0",
                     oLEN, oPAYLOAD, oER_CODE, oDROP_CNT);
        end
        iRESET = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        bit ok;
        send_frame(2, 120'h2211, 8'h00, 100);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL good_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_bad_checksum;
        bit ok;
        send_frame(3, 120'h332211, 8'h00, 4);
        gap(3);
        send_frame(2, 120'h2211, 8'h01, 100);
        gap(3);
        send_frame(2, 120'h2211, 8'h00, 5);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL badchk_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_bad_length;
        bit ok;
        push_err(3'd2);
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h00);
        n_checks++;
        if (oFRAME_ER !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_pulse got=%0b required=1", oFRAME_ER);
        end
        gap(2);
        push_err(3'd2);
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h09);
        gap(2);
        send_frame(8, 120'hF8E7D6C5B4A39281, 8'h00, 3);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL badlen_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_noise;
        bit         ok;
        logic [7:0] b;
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h5A) b = 8'h00;
            send_byte(b);
            m_drop++;
            if (i == 99) begin
                n_checks++;
                if (oDROP_CNT !== 8'(m_drop)) begin
                    n_fail++;
                    $display("FAIL drop_mid got=%0d required=%0d", oDROP_CNT, m_drop);
                end
            end
        end
        n_checks++;
        if (oDROP_CNT !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_sat got=%0d required=255", oDROP_CNT);
        end
        gap(2);
        send_frame(1, 120'h5A, 8'h00, 2);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL syncdata_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_timeout;
        bit   ok;
        int   seen;
        exp_t e;
        push_err(3'd4);
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h03);
        gap(2);
        send_byte(8'hAA);
        seen = -1;
        for (int n = 1; n <= int'(TMO) + 10; n++) begin
            @(negedge clk);
            if (oFRAME_ER === 1'b1) begin
                seen = n;
                break;
            end
        end
        n_checks++;
        if (seen != int'(TMO)) begin
            n_fail++;
            $display("FAIL timeout_delay got=%0d required=%0d", seen, TMO);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_drain pending=%0d required=0", sb.size());
        end
        gap(2);
        e.is_err  = 1'b0;
        e.code    = 3'd0;
        e.len     = 4'd3;
        e.payload = 64'hCCBBAA;
        m_len     = 4'd3;
        m_pay     = 64'hCCBBAA;
        sb.push_back(e);
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h03);
        gap(2);
        send_byte(8'hAA);
        gap(int'(TMO) - 1);
        send_byte(8'hBB);
        gap(2);
        send_byte(8'hCC);
        gap(2);
        send_byte(8'hDE);
        n_checks++;
        if (oFRAME_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL expiry_byte_valid got=%0b required=1", oFRAME_VALID);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL expiry_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_line_error;
        bit ok;
        push_err(3'd1);
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h03);
        gap(2);
        send_byte(8'h11);
        gap(2);
        iREC_ER = 1'b1;
        @(negedge clk);
        iREC_ER = 1'b0;
        n_checks++;
        if (oFRAME_ER !== 1'b1) begin
            n_fail++;
            $display("FAIL line_err_pulse got=%0b required=1", oFRAME_ER);
        end
        gap(3);
        push_err(3'd1);
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h02);
        gap(2);
        send_byte(8'h11);
        gap(2);
        iREC_ER  = 1'b1;
        iREC_END = 1'b1;
        iRX_BYTE = 8'h22;
        @(negedge clk);
        iREC_ER  = 1'b0;
        iREC_END = 1'b0;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL line_drain pending=%0d required=0", sb.size());
        end
        iREC_ER = 1'b1;
        @(negedge clk);
        iREC_ER = 1'b0;
        gap(3);
        n_checks++;
        if (oER_CODE !== 3'd1 || oBUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_line_err code=%0d busy=%0b required code=1 busy=0",
                     oER_CODE, oBUSY);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        send_byte(8'h5A);
        gap(2);
        send_byte(8'h03);
        gap(2);
        send_byte(8'h11);
        iRESET = 1'b0;
        @(negedge clk);
        iRESET = 1'b1;
        n_checks++;
        if ({oLEN, oPAYLOAD, oER_CODE, oDROP_CNT, oBUSY, oFRAME_VALID, oFRAME_ER} !== '0) begin
            n_fail++;
            $display("FAIL midreset_out len=%0d pay=%h code=%0d drop=%0d busy=%0b required=0",
                     oLEN, oPAYLOAD, oER_CODE, oDROP_CNT, oBUSY);
        end
        m_len  = 4'd0;
        m_pay  = 64'd0;
        m_drop = 0;
        gap(5);
        send_frame(2, 120'hEFBE, 8'h00, 3);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midreset_drain pending=%0d required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_noise();
        test_timeout();
        test_line_error();
        test_reset_mid_frame();
        gap(10);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
